sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Sequences the single external SRAM controller (`sram`) between two requesters: the video line fetch, which reads one 640-pixel line (40 × 16-bit words) into the line buffer during horizontal blanking, and the drawing path, which writes camera-derived pixel words. The arbiter sits between these requesters and the `sram` controller's `address`/`read`/`write`/`ready` interface. Line fetches have strict priority. Draw writes are buffered in a small FIFO and issued only when no fetch is active or pending.

## Interface
Parameters:
- `ADDR_W`, 18, SRAM word address width
- `DATA_W`, 16, SRAM word width
- `WORDS_PER_LINE`, 40, words fetched per video line
- `FIFO_DEPTH`, 4, draw-write FIFO entries (power of two)

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock (same clock as `sram`)
- `reset`  in  1  async active-high reset
- `fetch_start`  in  1  single-cycle request to fetch line `fetch_line`
- `fetch_line`  in  9  line number 0..479, sampled when `fetch_start`=1
- `fetch_busy`  out  1  fetch active or pending
- `fetch_valid`  out  1  one-cycle strobe: `fetch_data` is word `fetch_index`
- `fetch_index`  out  6  word index 0..WORDS_PER_LINE-1
- `fetch_data`  out  DATA_W  fetched word
- `fetch_done`  out  1  one-cycle strobe after last word
- `wr_req`  in  1  push draw write (accepted when `wr_req && wr_ready`)
- `wr_addr`  in  ADDR_W  draw write address
- `wr_data`  in  DATA_W  draw write data
- `wr_ready`  out  1  FIFO not full
- `sram_address`  out  ADDR_W  to `sram.address`
- `sram_data_write`  out  DATA_W  to `sram.data_write`
- `sram_read`  out  1  to `sram.read`
- `sram_write`  out  1  to `sram.write`
- `sram_ready`  in  1  from `sram.ready`, one-cycle completion pulse
- `sram_data_read`  in  DATA_W  from `sram.data_read`, valid when `sram_ready`=1

## Operation
- States: `IDLE`, `FETCH_REQ`, `FETCH_WAIT`, `WRITE_REQ`, `WRITE_WAIT`.
- `IDLE`: if a fetch is pending, go to `FETCH_REQ` with index 0. Otherwise, if the FIFO is non-empty, go to `WRITE_REQ`.
- `FETCH_REQ`: drive `sram_address = line*WORDS_PER_LINE + index`. Compute this in ADDR_W bits; the maximum value is 19199. Assert `sram_read`, then go to `FETCH_WAIT`.
- `FETCH_WAIT`: on `sram_ready`:
  - Capture `sram_data_read` and deassert `sram_read`.
  - Pulse `fetch_valid` with the current index.
  - If index = WORDS_PER_LINE-1, pulse `fetch_done` and go to `IDLE`. Otherwise increment the index and go to `FETCH_REQ`.
- A line burst is atomic: no writes are interleaved within it.
- `WRITE_REQ`: pop the FIFO head onto `sram_address`/`sram_data_write`, assert `sram_write`, then go to `WRITE_WAIT`.
- `WRITE_WAIT`: on `sram_ready`, deassert `sram_write` and go to `IDLE`. An in-flight write always completes before a fetch starts.
- Pending-fetch register (one deep):
  - `fetch_start` sets it and latches `fetch_line`.
  - It is cleared when entering `FETCH_REQ` for index 0.
  - `fetch_start` arriving during an active fetch sets pending for the new line (the new fetch runs after the current one).
  - A second `fetch_start` while already pending overwrites the latched line.
- FIFO: `wr_ready = !full`. A push while full is ignored. Simultaneous push and pop when full is allowed.
- `fetch_busy = pending || state ∈ {FETCH_REQ, FETCH_WAIT}`.

## Timing
- Reset values:
  - All outputs 0; `wr_ready` = 1 (FIFO empty).
  - State `IDLE`, pending cleared, FIFO emptied.
  - Reset asserted mid-transaction drops `sram_read`/`sram_write` asynchronously and discards all queued writes.
- All outputs are registered.
- `fetch_start` at cycle 0 with state `IDLE` → `sram_read`=1 with word-0 address at cycle 2.
- `sram_ready` sampled at cycle k:
  - `fetch_valid`/`fetch_data` appear at cycle k+1.
  - `sram_read` is 0 at cycle k+1.
  - The next `sram_read` rises at cycle k+2 (guaranteed one-cycle low gap between requests).
- `sram_read` and `sram_write` are never high together.
- `sram_address` and `sram_data_write` are stable while the request is high.
- `fetch_start` and `wr_req` in the same cycle while `IDLE`: the write is enqueued, and the fetch is served first.
- `sram_ready` outside a `*_WAIT` state is ignored.

## Structure
- Shared package `sram_pkg`:
  - `ADDR_W`, `DATA_W`, `WORDS_PER_LINE`, `LINES` (480).
  - The `arb_state_t` enum.
- Sub-module `sram_wr_fifo`: synchronous FIFO, FIFO_DEPTH × (ADDR_W+DATA_W), with full/empty flags, on the same `clk` and `reset`.

## Test plan
- Fetch of line 3, `sram` model with 2-cycle ready latency, word data = address → 40 `fetch_valid` pulses carrying data 120..159 in index order, then one `fetch_done`.
- Push 3 writes (addr 0x100/0x101/0x102, data 0x0FF0) while idle → three `sram_write` transactions in FIFO order, each separated by at least one idle cycle.
- Fill the FIFO with 4 writes while a fetch is running, then push a 5th → `wr_ready`=0 and the 5th write is dropped. All 4 queued writes issue only after `fetch_done`.
- Write in flight (ready delayed 5 cycles) plus `fetch_start` for line 479 → the write completes first. The fetch then reads addresses 19160..19199.
- `fetch_start` lines 10 and then 11 during an active fetch of line 9 → line 9 completes, then only line 11 is fetched.
- Assert `reset` in `FETCH_WAIT` → `sram_read`=0 immediately; after release, `fetch_busy`=0, `wr_ready`=1, and no spurious `fetch_valid`.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants and arbiter state encoding for the SRAM sequencing slice.
package sram_pkg;
    localparam int ADDR_W         = 18;
    localparam int DATA_W         = 16;
    localparam int WORDS_PER_LINE = 40;
    localparam int LINES          = 480;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_REQ  = 3'd1,
        FETCH_WAIT = 3'd2,
        WRITE_REQ  = 3'd3,
        WRITE_WAIT = 3'd4
    } arb_state_t;
endpackage

// File: rtl/sram_wr_fifo.sv
// Draw-write queue: power-of-two deep synchronous FIFO with registered full/empty status.
module sram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = sram_pkg::ADDR_W + sram_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             not_full,
    output logic             not_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign pop_data = mem_r[rd_ptr_r];

    // Accept/retire decisions; a push into a full FIFO is taken only if a pop frees a slot
    always_comb begin
        pop_ok_s     = pop && not_empty;
        push_ok_s    = push && (not_full || pop_ok_s);
        count_next_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage, pointers and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            not_full  <= 1'b1;
            not_empty <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r   <= count_next_s;
            not_full  <= (count_next_s != CNT_W'(DEPTH));
            not_empty <= (count_next_s != CNT_W'(0));
        end
    end
endmodule

// File: rtl/sram_arbiter.sv
// Shares the SRAM controller between the video line fetch (strict priority, atomic
// 40-word burst) and queued draw-path writes.
module sram_arbiter #(
    parameter int ADDR_W         = sram_pkg::ADDR_W,
    parameter int DATA_W         = sram_pkg::DATA_W,
    parameter int WORDS_PER_LINE = sram_pkg::WORDS_PER_LINE,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic [8:0]        fetch_line,
    output logic              fetch_busy,
    output logic              fetch_valid,
    output logic [5:0]        fetch_index,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_data_write,
    output logic              sram_read,
    output logic              sram_write,
    input  logic              sram_ready,
    input  logic [DATA_W-1:0] sram_data_read
);
    import sram_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(WORDS_PER_LINE - 1);

    arb_state_t               state_r;
    logic                     pending_r;
    logic [8:0]               pend_line_r;
    logic [8:0]               cur_line_r;
    logic [5:0]               idx_r;
    logic [ADDR_W-1:0]        fetch_addr_s;
    logic                     fifo_pop_s;
    logic                     fifo_not_empty_s;
    logic [ADDR_W+DATA_W-1:0] fifo_head_s;

    assign fetch_addr_s = ADDR_W'(cur_line_r) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(idx_r);
    assign fifo_pop_s   = (state_r == WRITE_REQ);

    sram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_req),
        .push_data ({wr_addr, wr_data}),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_head_s),
        .not_full  (wr_ready),
        .not_empty (fifo_not_empty_s)
    );

    // Arbitration FSM with registered SRAM and fetch outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            pending_r       <= 1'b0;
            pend_line_r     <= 9'd0;
            cur_line_r      <= 9'd0;
            idx_r           <= 6'd0;
            fetch_busy      <= 1'b0;
            fetch_valid     <= 1'b0;
            fetch_index     <= 6'd0;
            fetch_data      <= '0;
            fetch_done      <= 1'b0;
            sram_address    <= '0;
            sram_data_write <= '0;
            sram_read       <= 1'b0;
            sram_write      <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            fetch_done  <= 1'b0;
            fetch_busy  <= fetch_start || pending_r;
            if (fetch_start) begin
                pending_r   <= 1'b1;
                pend_line_r <= fetch_line;
            end
            case (state_r)
                IDLE: begin
                    // A start arriving this cycle is served directly, newest line wins
                    if (fetch_start || pending_r) begin
                        cur_line_r <= fetch_start ? fetch_line : pend_line_r;
                        pending_r  <= 1'b0;
                        idx_r      <= 6'd0;
                        fetch_busy <= 1'b1;
                        state_r    <= FETCH_REQ;
                    end else if (fifo_not_empty_s) begin
                        state_r <= WRITE_REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH_REQ: begin
                    sram_address <= fetch_addr_s;
                    sram_read    <= 1'b1;
                    fetch_busy   <= 1'b1;
                    state_r      <= FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (sram_ready) begin
                        sram_read   <= 1'b0;
                        fetch_valid <= 1'b1;
                        fetch_index <= idx_r;
                        fetch_data  <= sram_data_read;
                        if (idx_r == LAST_IDX) begin
                            fetch_done <= 1'b1;
                            state_r    <= IDLE;
                        end else begin
                            idx_r      <= idx_r + 6'd1;
                            fetch_busy <= 1'b1;
                            state_r    <= FETCH_REQ;
                        end
                    end else begin
                        fetch_busy <= 1'b1;
                        state_r    <= FETCH_WAIT;
                    end
                end
                WRITE_REQ: begin
                    sram_address    <= fifo_head_s[ADDR_W+DATA_W-1:DATA_W];
                    sram_data_write <= fifo_head_s[DATA_W-1:0];
                    sram_write      <= 1'b1;
                    state_r         <= WRITE_WAIT;
                end
                WRITE_WAIT: begin
                    if (sram_ready) begin
                        sram_write <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= WRITE_WAIT;
                    end
                end
                default: begin
                    sram_read  <= 1'b0;
                    sram_write <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a variable-latency SRAM model.
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_start = 1'b0;
    logic [8:0]  fetch_line = 9'd0;
    logic        fetch_busy, fetch_valid, fetch_done;
    logic [5:0]  fetch_index;
    logic [15:0] fetch_data;
    logic        wr_req = 1'b0;
    logic [17:0] wr_addr = 18'd0;
    logic [15:0] wr_data = 16'd0;
    logic        wr_ready;
    logic [17:0] sram_address;
    logic [15:0] sram_data_write;
    logic        sram_read, sram_write;
    logic        sram_ready;
    logic [15:0] sram_data_read;

    int checks = 0;
    int errors = 0;
    int lat = 2;

    sram_arbiter dut (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .fetch_line(fetch_line),
        .fetch_busy(fetch_busy), .fetch_valid(fetch_valid), .fetch_index(fetch_index),
        .fetch_data(fetch_data), .fetch_done(fetch_done), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .sram_address(sram_address),
        .sram_data_write(sram_data_write), .sram_read(sram_read), .sram_write(sram_write),
        .sram_ready(sram_ready), .sram_data_read(sram_data_read)
    );

    always #5 clk = ~clk;

    // SRAM model: one request at a time, ready pulses after `lat` cycles, read data = address
    logic in_flight;
    int   cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_ready     <= 1'b0;
            sram_data_read <= 16'd0;
            in_flight      <= 1'b0;
            cnt            <= 0;
        end else begin
            sram_ready <= 1'b0;
            if (in_flight) begin
                if (cnt <= 1) begin
                    sram_ready     <= 1'b1;
                    sram_data_read <= sram_address[15:0];
                    in_flight      <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end else if ((sram_read || sram_write) && !sram_ready) begin
                in_flight <= 1'b1;
                cnt       <= lat;
            end
        end
    end

    // Monitor: logs fetch words and completed writes, counts protocol violations
    int cyc = 0;
    int vld_cnt = 0, done_cnt = 0, done_bad = 0, wr_cnt = 0, viol = 0, wr_at_done = 0;
    int v_idx_log [1024];
    int v_data_log[1024];
    int v_cyc_log [1024];
    int w_addr_log[64];
    int w_data_log[64];
    int w_cyc_log [64];
    logic prev_req = 1'b0, prev_rdy = 1'b0, rd_rdy_d1 = 1'b0, rd_rdy_d2 = 1'b0, done_d1 = 1'b0;
    logic [17:0] prev_addr = 18'd0;
    logic [15:0] prev_wdata = 16'd0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            prev_req  <= 1'b0;
            prev_rdy  <= 1'b0;
            rd_rdy_d1 <= 1'b0;
            rd_rdy_d2 <= 1'b0;
            done_d1   <= 1'b0;
        end else begin
            if (fetch_valid && vld_cnt < 1024) begin
                v_idx_log[vld_cnt]  <= int'(fetch_index);
                v_data_log[vld_cnt] <= int'(fetch_data);
                v_cyc_log[vld_cnt]  <= cyc;
            end
            if (fetch_valid) vld_cnt <= vld_cnt + 1;
            if (fetch_done) begin
                done_cnt   <= done_cnt + 1;
                wr_at_done <= wr_cnt;
                if (!(fetch_valid && fetch_index == 6'd39)) done_bad <= done_bad + 1;
            end
            if (sram_write && sram_ready && wr_cnt < 64) begin
                w_addr_log[wr_cnt] <= int'(sram_address);
                w_data_log[wr_cnt] <= int'(sram_data_write);
                w_cyc_log[wr_cnt]  <= cyc;
                wr_cnt             <= wr_cnt + 1;
            end
            if (sram_read && sram_write) viol <= viol + 1;
            if (prev_rdy && (sram_read || sram_write)) viol <= viol + 1;
            if (prev_req && (sram_read || sram_write) &&
                (sram_address != prev_addr || sram_data_write != prev_wdata)) viol <= viol + 1;
            if (rd_rdy_d1 && !fetch_valid) viol <= viol + 1;
            if (rd_rdy_d2 && !done_d1 && !sram_read) viol <= viol + 1;
            prev_req   <= sram_read || sram_write;
            prev_rdy   <= sram_ready && (sram_read || sram_write);
            prev_addr  <= sram_address;
            prev_wdata <= sram_data_write;
            rd_rdy_d1  <= sram_ready && sram_read;
            rd_rdy_d2  <= rd_rdy_d1;
            done_d1    <= fetch_done;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= target) break;
            tick();
        end
        check(name, 32'(done_cnt >= target), 32'd1);
        tick();
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (wr_cnt >= target) break;
            tick();
        end
        check(name, 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic check_seq(input string name, input int base, input int first_word);
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (v_idx_log[base + i] != i || v_data_log[base + i] != first_word + i) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic pulse_fetch(input logic [8:0] line);
        fetch_line  = line;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
    endtask

    typedef struct {
        logic [8:0] line;
        int         latency;
        int         exp_first;
        int         exp_last;
    } fetch_vec_t;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
        logic        exp_ready;
    } push_vec_t;

    fetch_vec_t fvec[4];
    push_vec_t  pvec[5];

    initial begin
        int vb, db, wb;
        fvec[0] = '{9'd0,   1, 0,     39};
        fvec[1] = '{9'd100, 3, 4000,  4039};
        fvec[2] = '{9'd479, 1, 19160, 19199};
        fvec[3] = '{9'd7,   4, 280,   319};
        pvec[0] = '{18'h200, 16'h1111, 1'b1};
        pvec[1] = '{18'h201, 16'h2222, 1'b1};
        pvec[2] = '{18'h202, 16'h3333, 1'b1};
        pvec[3] = '{18'h203, 16'h4444, 1'b1};
        pvec[4] = '{18'h204, 16'h5555, 1'b0};

        // reset state
        tick(); tick();
        check("rst_read", 32'(sram_read), 32'd0);
        check("rst_write", 32'(sram_write), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        reset = 1'b0;
        tick();
        check("rst_busy", 32'(fetch_busy), 32'd0);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_done", 32'(fetch_done), 32'd0);
        check("rst_addr", 32'(sram_address), 32'd0);
        check("rst_wr_ready_rel", 32'(wr_ready), 32'd1);

        // line 3, latency 2: read at cycle 2 with word-0 address, data 120..159
        lat = 2;
        vb = vld_cnt; db = done_cnt;
        pulse_fetch(9'd3);
        check("c1_read_low", 32'(sram_read), 32'd0);
        check("c1_busy", 32'(fetch_busy), 32'd1);
        tick();
        check("c2_read", 32'(sram_read), 32'd1);
        check("c2_addr", 32'(sram_address), 32'd120);
        wait_done(db + 1, 1000, "l3_done_timeout");
        check("l3_count", 32'(vld_cnt - vb), 32'd40);
        check_seq("l3_seq", vb, 120);
        check("l3_busy_after", 32'(fetch_busy), 32'd0);

        // table of fetches across lines and latencies
        for (int t = 0; t < 4; t++) begin
            lat = fvec[t].latency;
            vb = vld_cnt; db = done_cnt;
            pulse_fetch(fvec[t].line);
            wait_done(db + 1, 2000, "tbl_done_timeout");
            check("tbl_count", 32'(vld_cnt - vb), 32'd40);
            check("tbl_first", 32'(v_data_log[vb]), 32'(fvec[t].exp_first));
            check("tbl_last", 32'(v_data_log[vb + 39]), 32'(fvec[t].exp_last));
            check_seq("tbl_seq", vb, fvec[t].exp_first);
        end

        // three writes while idle, issued in FIFO order
        lat = 2;
        wb = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1; wr_addr = 18'h100 + 18'(i); wr_data = 16'h0FF0;
            tick();
        end
        wr_req = 1'b0;
        wait_writes(wb + 3, 200, "w3_timeout");
        for (int i = 0; i < 3; i++) begin
            check("w3_addr", 32'(w_addr_log[wb + i]), 32'h100 + 32'(i));
            check("w3_data", 32'(w_data_log[wb + i]), 32'h0FF0);
        end

        // fill FIFO during a fetch; fifth push dropped, writes wait for fetch_done
        vb = vld_cnt; db = done_cnt; wb = wr_cnt;
        pulse_fetch(9'd5);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check("fill_ready", 32'(wr_ready), 32'(pvec[i].exp_ready));
            wr_req = 1'b1; wr_addr = pvec[i].addr; wr_data = pvec[i].data;
            tick();
        end
        wr_req = 1'b0;
        check("fill_ready_full", 32'(wr_ready), 32'd0);
        wait_done(db + 1, 2000, "fill_done_timeout");
        check("fill_no_write_before_done", 32'(wr_at_done), 32'(wb));
        check_seq("fill_seq", vb, 200);
        wait_writes(wb + 4, 300, "fill_wr_timeout");
        for (int i = 0; i < 30; i++) tick();
        check("fill_wr_count", 32'(wr_cnt - wb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("fill_addr", 32'(w_addr_log[wb + i]), 32'(pvec[i].addr));
            check("fill_data", 32'(w_data_log[wb + i]), 32'(pvec[i].data));
        end
        check("fill_ready_drained", 32'(wr_ready), 32'd1);

        // write in flight (slow SRAM) then fetch of line 479
        lat = 5;
        vb = vld_cnt; db = done_cnt; wb = wr_cnt;
        wr_req = 1'b1; wr_addr = 18'h300; wr_data = 16'hABCD;
        tick();
        wr_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sram_write) break;
            tick();
        end
        check("wf_write_started", 32'(sram_write), 32'd1);
        pulse_fetch(9'd479);
        check("wf_busy_pending", 32'(fetch_busy), 32'd1);
        check("wf_write_still", 32'(sram_write), 32'd1);
        wait_done(db + 1, 3000, "wf_done_timeout");
        check("wf_write_count", 32'(wr_cnt - wb), 32'd1);
        check("wf_write_first", 32'(w_cyc_log[wb] < v_cyc_log[vb]), 32'd1);
        check_seq("wf_seq", vb, 19160);

        // line 9 active, then 10 and 11 requested: only 9 and 11 are fetched
        lat = 2;
        vb = vld_cnt; db = done_cnt;
        pulse_fetch(9'd9);
        for (int i = 0; i < 10; i++) tick();
        pulse_fetch(9'd10);
        for (int i = 0; i < 5; i++) tick();
        pulse_fetch(9'd11);
        wait_done(db + 2, 3000, "ov_done_timeout");
        for (int i = 0; i < 100; i++) tick();
        check("ov_done_count", 32'(done_cnt - db), 32'd2);
        check("ov_count", 32'(vld_cnt - vb), 32'd80);
        check_seq("ov_seq9", vb, 360);
        check_seq("ov_seq11", vb + 40, 440);
        check("ov_busy", 32'(fetch_busy), 32'd0);

        // reset during FETCH_WAIT with queued writes
        pulse_fetch(9'd20);
        for (int i = 0; i < 2; i++) begin
            wr_req = 1'b1; wr_addr = 18'h400 + 18'(i); wr_data = 16'h0055;
            tick();
        end
        wr_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sram_read) break;
            tick();
        end
        check("rw_read_before", 32'(sram_read), 32'd1);
        #2 reset = 1'b1;
        #1 check("rw_read_async", 32'(sram_read), 32'd0);
        tick(); tick();
        reset = 1'b0;
        vb = vld_cnt; wb = wr_cnt;
        tick();
        check("rw_busy", 32'(fetch_busy), 32'd0);
        check("rw_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 60; i++) tick();
        check("rw_no_valid", 32'(vld_cnt - vb), 32'd0);
        check("rw_no_write", 32'(wr_cnt - wb), 32'd0);

        check("protocol_violations", 32'(viol), 32'd0);
        check("done_alignment", 32'(done_bad), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
